load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU in the rv32i datapath.
- Takes the ALU result as the effective address, and rs2 as the store data.
- Runs one load or store per request over a simple req/ack data bus, with byte-lane enables and load sign/zero extension.
- Flags misaligned or illegal accesses and bus timeouts, and reports completion with a one-cycle done pulse.

Parameters:
- TIMEOUT, 16, number of cycles bus_req may stay high without bus_ack before the access aborts with err; 0 disables the timeout.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request strobe from control; sampled only when busy=0
- mem_write  input  1  1=store, 0=load; captured at start
- funct3  input  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only); captured at start
- addr  input  32  effective address (ALU res); captured at start
- wdata  input  32  store data (rs2); captured at start
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle completion pulse
- err  output  1  valid with done: misaligned, illegal funct3, or timeout
- rdata  output  32  extended load result; held until the next successful load
- bus_req  output  1  bus request, held until ack or abort
- bus_we  output  1  bus write enable
- bus_addr  output  32  word address {addr[31:2],2'b00}
- bus_be  output  4  byte-lane enables
- bus_wdata  output  32  lane-replicated store data
- bus_ack  input  1  bus completion; meaningful only while bus_req=1
- bus_rdata  input  32  read word, valid in the bus_ack cycle

Behaviour:
- Reset (synchronous): state IDLE, timeout counter 0. All outputs are 0 from the first edge with rst=1: busy, done, err, rdata, bus_req, bus_we, bus_addr, bus_be, bus_wdata. Reset mid-access drops bus_req at that edge, and any later bus_ack is ignored.
- States: IDLE, REQ, FAIL.
- IDLE, start=1 at edge N: capture mem_write, funct3, addr and wdata.
  - Legality check: W needs addr[1:0]=00; H/HU need addr[0]=0; store funct3 must be 000/001/010; load funct3 011/110/111 are illegal.
  - Illegal access -> FAIL. Legal access -> REQ.
- start while busy=1 is ignored with no queueing.
- FAIL: lasts one cycle, with no bus activity. Then back to IDLE with done=1, err=1, rdata unchanged. Timing: start at N, done at N+2.
- REQ: bus_req=1 from cycle N+1. bus_we, bus_addr, bus_be and bus_wdata are stable for the whole request.
  - bus_be: B/BU = 0001<<addr[1:0]; H/HU = 0011<<addr[1:0]; W = 1111. Loads use the same lanes.
  - bus_wdata: B = {4{wdata[7:0]}}; H = {2{wdata[15:0]}}; W = wdata.
- bus_ack=1 in REQ cycle M:
  - Next cycle: state IDLE, bus_req=0 and bus_be=0, done=1, err=0.
  - Load: rdata = selected lane from the bus_rdata sampled at M. B/H are sign-extended; BU/HU are zero-extended.
  - Store: rdata unchanged.
  - Minimum latency: start N, ack N+1, done N+2.
- Timeout (TIMEOUT>0): the counter clears on entry to REQ and increments each REQ cycle without ack.
  - On the TIMEOUT-th consecutive REQ cycle with no ack: abort to IDLE, bus_req=0, done=1, err=1, rdata unchanged.
  - If ack arrives in that same cycle, ack wins and the access succeeds.
- done and err are never high outside the done cycle; err is 0 whenever done=0.
- busy=0 in the done cycle, so a start in the done cycle is accepted (back-to-back accesses).
- bus_ack while bus_req=0 is ignored.

Test Plan:
- LW aligned: addr=0x0000_1004, ack on first REQ cycle, bus_rdata=0xDEAD_BEEF -> bus_addr=0x1004, bus_be=1111, done at start+2, rdata=0xDEADBEEF, err=0.
- LB/LBU lane select: addr=0x103, bus_rdata=0x80AA_BBCC. LB -> be=1000, rdata=0xFFFF_FF80. LBU -> rdata=0x0000_0080. Also LH at addr=0x102 -> rdata=0xFFFF_80AA.
- SB/SH stores: SB addr=0x201, wdata=0x1234_5678 -> be=0010, bus_wdata=0x7878_7878, bus_we=1. SH addr=0x202 -> be=1100, bus_wdata=0x5678_5678. rdata unchanged in both.
- Misaligned/illegal: LW addr=0x102, then SB with funct3=100 -> no bus_req, done+err at start+2 for each.
- Timeout, TIMEOUT=4, ack never given: bus_req high for exactly 4 cycles, then done=1, err=1, bus_req=0. Repeat with ack on the 4th cycle -> success, err=0.
- Reset mid-access: rst=1 on the 2nd REQ cycle -> bus_req=0 next edge, all outputs 0. A following ack is ignored, and the next start completes normally. Back-to-back start issued in the done cycle is accepted.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: rv32i memory-access stage. It takes the ALU result as the
// effective address and rs2 as the store data, and runs one load or store per
// request over a req/ack data bus. The unit drives byte-lane enables, sign- or
// zero-extends load results, and flags misaligned/illegal accesses and bus
// timeouts. Completion is reported with a one-cycle done pulse.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             request strobe, sampled only while busy=0
//   mem_write         1=store, 0=load
//   funct3            access size (B/H/W/BU/HU)
//   addr, wdata       effective address and store data
//   busy              state != IDLE
//   done, err         completion pulse; err qualifies done
//   rdata             extended load result, held until the next good load
//   bus_req/we/addr/be/wdata   request side of the data bus
//   bus_ack, bus_rdata         response side of the data bus
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, FAIL} state_t;

    // Load context kept for the response: size/sign and byte offset in word.
    typedef struct packed {
        logic [2:0] funct3;
        logic [1:0] off;
    } ld_ctx_t;

    // Counter only has to reach TIMEOUT-1.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t          state;
    ld_ctx_t         ld_ctx;
    logic [CW-1:0]   cnt;

    function automatic logic is_legal(input logic we, input logic [2:0] f3,
                                      input logic [1:0] a);
        case (f3)
            3'b000:  is_legal = 1'b1;
            3'b001:  is_legal = ~a[0];
            3'b010:  is_legal = (a == 2'b00);
            3'b100:  is_legal = ~we;
            3'b101:  is_legal = ~we & ~a[0];
            default: is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   lane_be = 4'b0001 << a;
            2'b01:   lane_be = 4'b0011 << a;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_repl(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   lane_repl = {4{d[7:0]}};
            2'b01:   lane_repl = {2{d[15:0]}};
            default: lane_repl = d;
        endcase
    endfunction

    // Shift the addressed lane down to bit 0, then extend by size/sign.
    function automatic logic [31:0] load_ext(input ld_ctx_t c, input logic [31:0] w);
        logic [31:0] sh;
        sh = w >> {c.off, 3'b000};
        case (c.funct3)
            3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
            3'b100:  load_ext = {24'h0, sh[7:0]};
            3'b001:  load_ext = {{16{sh[15]}}, sh[15:0]};
            3'b101:  load_ext = {16'h0, sh[15:0]};
            default: load_ext = sh;
        endcase
    endfunction

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ld_ctx    <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_legal(mem_write, funct3, addr[1:0])) begin
                            state     <= REQ;
                            cnt       <= '0;
                            ld_ctx    <= '{funct3: funct3, off: addr[1:0]};
                            bus_req   <= 1'b1;
                            bus_we    <= mem_write;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_be    <= lane_be(funct3, addr[1:0]);
                            bus_wdata <= lane_repl(funct3, wdata);
                        end else begin
                            state <= FAIL;
                        end
                    end
                end
                FAIL: begin
                    state <= IDLE;
                    done  <= 1'b1;
                    err   <= 1'b1;
                end
                REQ: begin
                    // Ack takes priority over a timeout in the same cycle.
                    if (bus_ack) begin
                        state   <= IDLE;
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        bus_be  <= '0;
                        done    <= 1'b1;
                        if (!bus_we)
                            rdata <= load_ext(ld_ctx, bus_rdata);
                    end else if (TIMEOUT > 0 && cnt == CW'(TIMEOUT - 1)) begin
                        state   <= IDLE;
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        bus_be  <= '0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (TIMEOUT=4). The driver issues accesses
// and pushes the expected completion into a queue; a negedge monitor pops an
// entry whenever done is seen and checks err, rdata and the done cycle.
module tb_load_store_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    load_store_unit #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy),
        .done(done), .err(err), .rdata(rdata), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Completion monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (err && !done) begin
                n_bad++;
                $display("FAIL err_without_done: err=1 done=0 (cycle %0d)", cyc);
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_done: done=1 with nothing outstanding (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_err", err, e.err);
                    chk("done_rdata", rdata, e.rdata);
                    chk("done_cycle", cyc, e.cyc);
                    chk("done_busy", busy, 1'b0);
                end
            end
        end
    end

    // Issues one access from the current cycle. ebe=0 marks an access that must
    // be rejected without touching the bus. ack_at<0 means never acknowledge.
    // Returns #1 into the done cycle so the next call is back-to-back.
    task automatic do_access(input string nm, input logic we, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int ack_at, input logic [31:0] rd,
                             input logic [3:0] ebe, input logic [31:0] ewd,
                             input logic eerr, input logic [31:0] erd);
        exp_t e;
        int   s;
        int   k;
        int   exp_k;
        start = 1'b1; mem_write = we; funct3 = f3; addr = a; wdata = wd;
        s = cyc;
        exp_k = (ack_at >= 0 && ack_at < TMO) ? ack_at + 1 : TMO;
        e.err   = eerr;
        e.rdata = erd;
        if (ebe == 4'b0000) e.cyc = s + 2;
        else                e.cyc = s + 1 + exp_k;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        if (ebe == 4'b0000) begin
            chk({nm, "_noreq1"}, bus_req, 1'b0);
            chk({nm, "_busy"}, busy, 1'b1);
            @(posedge clk); #1;
            chk({nm, "_noreq2"}, bus_req, 1'b0);
        end else begin
            chk({nm, "_we"}, bus_we, we);
            chk({nm, "_be"}, bus_be, ebe);
            chk({nm, "_addr"}, bus_addr, {a[31:2], 2'b00});
            chk({nm, "_wdata"}, bus_wdata, ewd);
            k = 0;
            while (bus_req && k < 40) begin
                if (k == ack_at) begin
                    bus_ack = 1'b1;
                    bus_rdata = rd;
                end
                @(posedge clk); #1;
                bus_ack = 1'b0;
                bus_rdata = '0;
                k++;
                if (bus_req) chk({nm, "_be_stable"}, bus_be, ebe);
            end
            chk({nm, "_req_cycles"}, k, exp_k);
            chk({nm, "_be_clear"}, bus_be, 4'b0000);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_req", bus_req, 1'b0);
        chk("rst_we", bus_we, 1'b0);
        chk("rst_addr", bus_addr, 32'h0);
        chk("rst_be", bus_be, 4'h0);
        chk("rst_wdata", bus_wdata, 32'h0);
        rst = 1'b0;

        //        name     we    f3      addr          wdata         ack rdata         be       bus_wdata     err   rdata
        do_access("lw",    1'b0, 3'b010, 32'h0000_1004, 32'h0,        0, 32'hDEAD_BEEF, 4'b1111, 32'h0,        1'b0, 32'hDEAD_BEEF);
        do_access("lb",    1'b0, 3'b000, 32'h0000_0103, 32'h0,        0, 32'h80AA_BBCC, 4'b1000, 32'h0,        1'b0, 32'hFFFF_FF80);
        do_access("lbu",   1'b0, 3'b100, 32'h0000_0103, 32'h0,        0, 32'h80AA_BBCC, 4'b1000, 32'h0,        1'b0, 32'h0000_0080);
        do_access("lh",    1'b0, 3'b001, 32'h0000_0102, 32'h0,        0, 32'h80AA_BBCC, 4'b1100, 32'h0,        1'b0, 32'hFFFF_80AA);
        do_access("sb",    1'b1, 3'b000, 32'h0000_0201, 32'h1234_5678, 0, 32'hFFFF_FFFF, 4'b0010, 32'h7878_7878, 1'b0, 32'hFFFF_80AA);
        do_access("sh",    1'b1, 3'b001, 32'h0000_0202, 32'h1234_5678, 1, 32'hFFFF_FFFF, 4'b1100, 32'h5678_5678, 1'b0, 32'hFFFF_80AA);
        do_access("lw_mis",1'b0, 3'b010, 32'h0000_0102, 32'h0,        0, 32'h0,         4'b0000, 32'h0,        1'b1, 32'hFFFF_80AA);
        do_access("sb_ill",1'b1, 3'b100, 32'h0000_0200, 32'h1234_5678, 0, 32'h0,        4'b0000, 32'h0,        1'b1, 32'hFFFF_80AA);
        do_access("lw_tmo",1'b0, 3'b010, 32'h0000_1008, 32'h0,       -1, 32'h0,         4'b1111, 32'h0,        1'b1, 32'hFFFF_80AA);
        do_access("lw_ack4",1'b0,3'b010, 32'h0000_100C, 32'h0,        3, 32'h1357_2468, 4'b1111, 32'h0,        1'b0, 32'h1357_2468);
        do_access("lhu",   1'b0, 3'b101, 32'h0000_0106, 32'h0,        1, 32'h9ABC_0000, 4'b1100, 32'h0,        1'b0, 32'h0000_9ABC);
        do_access("sw",    1'b1, 3'b010, 32'h0000_0300, 32'hA5A5_0F0F, 2, 32'h0,        4'b1111, 32'hA5A5_0F0F, 1'b0, 32'h0000_9ABC);

        // Reset in the second REQ cycle of a load, then a stray ack.
        start = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_3000; wdata = '0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("mid_req1", bus_req, 1'b1);
        @(posedge clk); #1;
        chk("mid_req2", bus_req, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_req", bus_req, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_rdata", rdata, 32'h0);
        chk("mid_rst_be", bus_be, 4'h0);
        chk("mid_rst_addr", bus_addr, 32'h0);
        chk("mid_rst_wdata", bus_wdata, 32'h0);
        rst = 1'b0;
        bus_ack = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        bus_rdata = '0;
        chk("stray_ack_busy", busy, 1'b0);
        @(posedge clk); #1;
        chk("stray_ack_rdata", rdata, 32'h0);
        chk("stray_ack_done", done, 1'b0);

        do_access("post_rst", 1'b0, 3'b010, 32'h0000_2000, 32'h0, 0, 32'hCAFE_F00D, 4'b1111, 32'h0, 1'b0, 32'hCAFE_F00D);
        do_access("b2b_lb",   1'b0, 3'b000, 32'h0000_2001, 32'h0, 0, 32'h0000_7F00, 4'b0010, 32'h0, 1'b0, 32'h0000_007F);

        // Let the last completion drain into the monitor.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_done: %0d completions never seen, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
